// File: rtl/append_frame_footer.sv
// -----------------------------------------------------------------------------
// append_frame_footer
//
// Streams an AXI-Stream frame through unchanged and then appends a footer.
// The footer is the timestamp, least-significant DATA_WIDTH chunk first. When
// ENABLE_FRAME_LENGTH_FOOTER is set, the frame byte length follows, also LS
// chunk first. The timestamp is consumed together with the first frame beat
// (TIMESTAMP_SAMPLE_AT_SOF = 1) or with the last frame beat (= 0). A
// single-beat frame always consumes it on that beat.
//
// Ports
//   clk, rstn                   : clock, asynchronous active-low reset
//   s_axis_t{data,valid,ready,last}
//                               : frame input (tlast is not forwarded)
//   s_axis_timestamp_t{data,valid,ready}
//                               : timestamp input, one handshake per frame
//   m_axis_t{data,valid,ready,last}
//                               : registered frame + footer output; tlast
//                                 marks the final footer beat only
// -----------------------------------------------------------------------------
module append_frame_footer #(
  parameter int DATA_WIDTH                 = 8,
  parameter int TIMESTAMP_WIDTH            = 72,
  parameter int FRAME_LENGTH_WIDTH         = 16,
  parameter bit ENABLE_FRAME_LENGTH_FOOTER = 1'b0,
  parameter bit TIMESTAMP_SAMPLE_AT_SOF    = 1'b0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [TIMESTAMP_WIDTH-1:0] s_axis_timestamp_tdata,
  input  logic                       s_axis_timestamp_tvalid,
  output logic                       s_axis_timestamp_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
);

  localparam int TS_BEATS       = TIMESTAMP_WIDTH / DATA_WIDTH;
  localparam int LEN_BEATS      = ENABLE_FRAME_LENGTH_FOOTER ? FRAME_LENGTH_WIDTH / DATA_WIDTH : 0;
  localparam int FOOTER_BEATS   = TS_BEATS + LEN_BEATS;
  localparam int FOOTER_WIDTH   = FOOTER_BEATS * DATA_WIDTH;
  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int CNT_WIDTH      = $clog2(FOOTER_BEATS + 1);

  localparam logic [CNT_WIDTH-1:0]          LAST_CNT   = CNT_WIDTH'(FOOTER_BEATS - 1);
  localparam logic [FRAME_LENGTH_WIDTH-1:0] LEN_MAX    = '1;
  localparam logic [FRAME_LENGTH_WIDTH:0]   BEAT_BYTES = (FRAME_LENGTH_WIDTH + 1)'(BYTES_PER_BEAT);

  typedef enum logic [1:0] {IDLE, FRAME, FOOTER} state_t;

  state_t state, state_next;

  logic out_free;
  logic sample_beat;
  logic frame_ready;
  logic frame_take;
  logic ts_take;
  logic footer_step;
  logic footer_end;

  logic [FRAME_LENGTH_WIDTH-1:0]                 byte_cnt;
  logic [FRAME_LENGTH_WIDTH:0]                   byte_sum;
  logic [FRAME_LENGTH_WIDTH-1:0]                 byte_cnt_next;
  logic [TIMESTAMP_WIDTH-1:0]                    ts_hold;
  logic [TIMESTAMP_WIDTH-1:0]                    ts_sel;
  logic [TIMESTAMP_WIDTH+FRAME_LENGTH_WIDTH-1:0] footer_image;
  logic [FOOTER_WIDTH-1:0]                       footer_sr;
  logic [CNT_WIDTH-1:0]                          footer_cnt;

  // The output register can take a new beat when empty or being drained.
  assign out_free = !m_axis_tvalid || m_axis_tready;

  // In SOF mode the first beat of a frame is the one taken in IDLE; that also
  // covers single-beat frames. Otherwise the tlast beat carries the timestamp.
  assign sample_beat = TIMESTAMP_SAMPLE_AT_SOF ? (state == IDLE) : s_axis_tlast;

  // Byte count including the beat being accepted, saturating instead of wrapping.
  assign byte_sum      = {1'b0, byte_cnt} + BEAT_BYTES;
  assign byte_cnt_next = byte_sum[FRAME_LENGTH_WIDTH] ? LEN_MAX : byte_sum[FRAME_LENGTH_WIDTH-1:0];

  // On an end-of-frame sample the timestamp comes straight from the port,
  // otherwise from the copy latched at start of frame.
  assign ts_sel       = ts_take ? s_axis_timestamp_tdata : ts_hold;
  assign footer_image = {byte_cnt_next, ts_sel};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    frame_ready = 1'b0;
    frame_take  = 1'b0;
    ts_take     = 1'b0;
    footer_step = 1'b0;
    footer_end  = 1'b0;
    case (state)
      IDLE, FRAME: begin
        frame_ready = rstn && out_free && (!sample_beat || s_axis_timestamp_tvalid);
        frame_take  = s_axis_tvalid && frame_ready;
        ts_take     = frame_take && sample_beat;
        if (frame_take) state_next = s_axis_tlast ? FOOTER : FRAME;
      end
      FOOTER: begin
        footer_step = out_free;
        // Leave as soon as the last footer beat enters the output register so
        // the next frame's first beat can follow without a bubble.
        footer_end  = out_free && (footer_cnt == LAST_CNT);
        if (footer_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_axis_tready           = frame_ready;
  assign s_axis_timestamp_tready = ts_take;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      byte_cnt      <= '0;
      ts_hold       <= '0;
      footer_sr     <= '0;
      footer_cnt    <= '0;
    end else if (frame_take) begin
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= 1'b0;
      byte_cnt      <= byte_cnt_next;
      if (ts_take) ts_hold <= s_axis_timestamp_tdata;
      if (s_axis_tlast) begin
        footer_sr  <= footer_image[FOOTER_WIDTH-1:0];
        footer_cnt <= '0;
      end
    end else if (footer_step) begin
      m_axis_tdata  <= footer_sr[DATA_WIDTH-1:0];
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= footer_end;
      footer_sr     <= footer_sr >> DATA_WIDTH;
      if (footer_end) begin
        footer_cnt <= '0;
        byte_cnt   <= '0;
      end else begin
        footer_cnt <= footer_cnt + CNT_WIDTH'(1);
      end
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_append_frame_footer.sv
// -----------------------------------------------------------------------------
// tb_append_frame_footer
//
// Four instances of append_frame_footer share one clock and reset:
//   0: defaults (8-bit, 72-bit timestamp, no length, sample at EOF)
//   1: 8-bit, length footer 16 bits, sample at EOF
//   2: 32-bit, 96-bit timestamp, 32-bit length, sample at EOF
//   3: 8-bit, 8-bit length (saturates at 255), sample at SOF
// One instance is exercised at a time. The expected output is derived from
// the accepted input beats and the timestamp seen at the sampling beat.
// -----------------------------------------------------------------------------
module tb_append_frame_footer;

  localparam int NI = 4;
  localparam logic [127:0] TS72 = 128'hABFEDCBA9876543210;
  localparam logic [127:0] TS96 = 128'h5A17C3ABFEDCBA9876543210;

  function automatic int dw_of(input int g);
    return (g == 2) ? 32 : 8;
  endfunction
  function automatic int tsw_of(input int g);
    return (g == 2) ? 96 : 72;
  endfunction
  function automatic int lw_of(input int g);
    return (g == 2) ? 32 : ((g == 3) ? 8 : 16);
  endfunction
  function automatic bit en_of(input int g);
    return g != 0;
  endfunction
  function automatic bit sof_of(input int g);
    return g == 3;
  endfunction

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  logic [NI-1:0][63:0]  s_data;
  logic [NI-1:0]        s_valid, s_last, ts_valid, m_ready;
  logic [NI-1:0][127:0] ts_data;
  logic [NI-1:0]        s_ready, ts_ready, m_valid, m_last;
  logic [NI-1:0][63:0]  m_data;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW  = dw_of(g);
    localparam int TSW = tsw_of(g);
    logic [DW-1:0] md;
    logic sr, tr, mv, ml;
    append_frame_footer #(
      .DATA_WIDTH                (DW),
      .TIMESTAMP_WIDTH           (TSW),
      .FRAME_LENGTH_WIDTH        (lw_of(g)),
      .ENABLE_FRAME_LENGTH_FOOTER(en_of(g)),
      .TIMESTAMP_SAMPLE_AT_SOF   (sof_of(g))
    ) u_dut (
      .clk                    (clk),
      .rstn                   (rstn),
      .s_axis_tdata           (s_data[g][DW-1:0]),
      .s_axis_tvalid          (s_valid[g]),
      .s_axis_tready          (sr),
      .s_axis_tlast           (s_last[g]),
      .s_axis_timestamp_tdata (ts_data[g][TSW-1:0]),
      .s_axis_timestamp_tvalid(ts_valid[g]),
      .s_axis_timestamp_tready(tr),
      .m_axis_tdata           (md),
      .m_axis_tvalid          (mv),
      .m_axis_tready          (m_ready[g]),
      .m_axis_tlast           (ml)
    );
    assign s_ready[g]  = sr;
    assign ts_ready[g] = tr;
    assign m_valid[g]  = mv;
    assign m_last[g]   = ml;
    assign m_data[g]   = 64'(md);
  end

  int checks   = 0;
  int failures = 0;

  // Stimulus and model state for the instance under test.
  logic [64:0]  sbeats[$];  // {last, data}
  logic [65:0]  expq[$];    // {is_footer, last, data}
  int           k, bi, pos, vpct, rpct, ts_low, ts_hs, stall_cnt, footer_pops;
  bit           ts_vary, gapless, pending, prev_hold;
  logic [64:0]  prev_out;
  logic [127:0] ts_cap;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Footer per the frame rules: timestamp chunks LS first, then the saturated
  // byte length LS first; tlast on the final chunk.
  function automatic void push_footer(input int nbeats);
    int dw, n_ts, n_len;
    longint unsigned len, lim;
    logic [127:0] t;
    logic [63:0]  mask;
    dw    = dw_of(k);
    n_ts  = tsw_of(k) / dw;
    n_len = en_of(k) ? lw_of(k) / dw : 0;
    mask  = (dw == 64) ? '1 : ((64'd1 << dw) - 64'd1);
    len   = longint'(nbeats) * longint'(dw / 8);
    lim   = (64'd1 << lw_of(k)) - 64'd1;
    if (len > lim) len = lim;
    for (int j = 0; j < n_ts + n_len; j++) begin
      if (j < n_ts) t = ts_cap >> (j * dw);
      else          t = 128'(len) >> ((j - n_ts) * dw);
      expq.push_back({1'b1, (j == n_ts + n_len - 1), t[63:0] & mask});
    end
  endfunction

  task automatic add_frame(input int nbeats);
    logic [63:0] d, mask;
    mask = (dw_of(k) == 64) ? '1 : ((64'd1 << dw_of(k)) - 64'd1);
    for (int i = 0; i < nbeats; i++) begin
      d = {$urandom(), $urandom()} & mask;
      sbeats.push_back({(i == nbeats - 1), d});
    end
  endtask

  task automatic idle_inputs(input int g);
    s_valid[g]  = 1'b0;
    s_last[g]   = 1'b0;
    s_data[g]   = '0;
    m_ready[g]  = 1'b1;
    ts_valid[g] = 1'b1;
  endtask

  // One clock: drive just after the rising edge, observe at the falling edge
  // (the values observed are exactly those the next rising edge will sample).
  task automatic step();
    logic samp, acc;
    logic [64:0] b;
    logic [65:0] e;
    @(posedge clk); #1;
    if (!pending) s_valid[k] = (bi < sbeats.size()) && ($urandom_range(99) < vpct);
    if (bi < sbeats.size()) begin
      b = sbeats[bi];
      s_data[k] = b[63:0];
      s_last[k] = b[64];
    end else begin
      s_data[k] = '0;
      s_last[k] = 1'b0;
    end
    m_ready[k] = ($urandom_range(99) < rpct);
    samp = s_valid[k] && (sof_of(k) ? (pos == 0) : s_last[k]);
    if (samp && ts_low > 0) begin
      ts_valid[k] = 1'b0;
      ts_low--;
    end else begin
      ts_valid[k] = 1'b1;
    end
    if (ts_vary) ts_data[k] = {$urandom(), $urandom(), $urandom(), $urandom()};

    @(negedge clk);
    acc = s_valid[k] && s_ready[k];
    check("ts_tready", ts_ready[k], acc && samp);
    if (samp && !ts_valid[k]) check("stall_without_ts", s_ready[k], 1'b0);
    if (s_valid[k] && !acc) stall_cnt++;
    if (gapless && expq.size() > 0) check("no_bubble", m_valid[k], 1'b1);
    if (prev_hold) check("output_hold", {m_valid[k], m_last[k], m_data[k]}, {1'b1, prev_out});
    prev_hold = m_valid[k] && !m_ready[k];
    prev_out  = {m_last[k], m_data[k]};
    if (m_valid[k] && m_ready[k]) begin
      if (expq.size() == 0) begin
        check("extra_beat_valid", m_valid[k], 1'b0);
      end else begin
        e = expq.pop_front();
        if (e[65]) begin
          check("footer_beat", {m_last[k], m_data[k]}, e[64:0]);
          footer_pops++;
        end else begin
          check("frame_beat", {m_last[k], m_data[k]}, e[64:0]);
        end
      end
    end
    pending = s_valid[k] && !acc;
    if (acc) begin
      if (samp) begin
        ts_cap = ts_data[k];
        ts_hs++;
      end
      expq.push_back({2'b00, s_data[k]});
      if (s_last[k]) begin
        push_footer(pos + 1);
        pos = 0;
      end else begin
        pos++;
      end
      bi++;
    end
  endtask

  task automatic run(input int kk, input int v, input int r, input int abort_pops);
    int budget;
    budget = 0;
    k = kk; vpct = v; rpct = r;
    bi = 0; pos = 0; pending = 1'b0; prev_hold = 1'b0;
    ts_hs = 0; stall_cnt = 0; footer_pops = 0;
    expq.delete();
    while (!(bi == sbeats.size() && expq.size() == 0)) begin
      if (abort_pops > 0 && footer_pops == abort_pops) break;
      if (budget > 5000) begin
        check("timeout_pending_items", 32'(expq.size() + sbeats.size() - bi), 32'd0);
        break;
      end
      budget++;
      step();
    end
    @(posedge clk); #1;
    idle_inputs(k);
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      idle_inputs(g);
      ts_data[g] = (g == 2) ? TS96 : TS72;
      s_valid[g] = 1'b1;  // ready must stay low in reset even with valid offered
    end
    ts_vary = 1'b0; gapless = 1'b0; ts_low = 0;

    // Reset values
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst_m_valid",  m_valid[g],  1'b0);
      check("rst_m_data",   m_data[g],   64'd0);
      check("rst_m_last",   m_last[g],   1'b0);
      check("rst_s_tready", s_ready[g],  1'b0);
      check("rst_ts_tready", ts_ready[g], 1'b0);
      s_valid[g] = 1'b0;
    end
    rstn = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      check("post_rst_s_tready",  s_ready[g],  1'b1);
      check("post_rst_ts_tready", ts_ready[g], 1'b0);
    end

    // Defaults, 64-byte frame, random handshakes
    sbeats.delete(); k = 0; add_frame(64);
    run(0, 70, 70, 0);
    check("i0_ts_handshakes", ts_hs, 1);

    // Length footer enabled, 64-byte frame -> length bytes 40,00
    sbeats.delete(); k = 1; add_frame(64);
    run(1, 60, 60, 0);
    check("i1_ts_handshakes", ts_hs, 1);

    // 32-bit stream, 96-bit timestamp, 32-bit length, 15 beats -> 0x3C
    sbeats.delete(); k = 2; add_frame(15);
    run(2, 75, 65, 0);
    check("i2_ts_handshakes", ts_hs, 1);

    // SOF sampling with the timestamp withheld for 5 cycles
    sbeats.delete(); k = 3; add_frame(10);
    ts_vary = 1'b1; ts_low = 5;
    run(3, 100, 100, 0);
    check("sof_stall_cycles", stall_cnt, 5);
    check("sof_ts_handshakes", ts_hs, 1);

    // Length saturation: 300 bytes in an 8-bit field -> 255
    sbeats.delete(); k = 3; add_frame(300);
    run(3, 80, 80, 0);
    check("sat_ts_handshakes", ts_hs, 1);
    ts_vary = 1'b0;

    // Single-beat frame then back-to-back frames at full rate
    sbeats.delete(); k = 0; add_frame(1); add_frame(3); add_frame(2);
    gapless = 1'b1;
    run(0, 100, 100, 0);
    check("b2b_ts_handshakes", ts_hs, 3);
    gapless = 1'b0;

    // Reset after the fourth footer beat, then a clean 64-byte frame
    sbeats.delete(); k = 0; add_frame(64);
    run(0, 100, 100, 4);
    check("abort_footer_pops", footer_pops, 4);
    s_valid[0] = 1'b1;
    rstn = 1'b0;
    #1;
    check("midrst_m_valid",   m_valid[0],  1'b0);
    check("midrst_m_data",    m_data[0],   64'd0);
    check("midrst_m_last",    m_last[0],   1'b0);
    check("midrst_s_tready",  s_ready[0],  1'b0);
    check("midrst_ts_tready", ts_ready[0], 1'b0);
    repeat (2) @(negedge clk);
    idle_inputs(0);
    rstn = 1'b1;
    sbeats.delete(); add_frame(64);
    run(0, 85, 70, 0);
    check("after_rst_ts_handshakes", ts_hs, 1);

    // Nothing consumes a timestamp without a frame
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("idle_ts_tready", ts_ready[g], 1'b0);
      check("idle_m_valid",   m_valid[g],  1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
